// File: rtl/ysyx_23060208_ifu_fetch_pkg.sv
// rtl/ysyx_23060208_ifu_fetch_pkg.sv - shared constants, state encoding and PC helper for the fetch stage
package ysyx_23060208_ifu_fetch_pkg;

    localparam int          IFU_TO_IDU_BUS_W = 64;
    localparam int          EXU_TO_IFU_BUS_W = 33;
    localparam logic [31:0] RESET_PC_DEF     = 32'h8000_0000;
    localparam logic [31:0] EBREAK_INST      = 32'h0010_0073;

    localparam logic [7:0]  AXI_LEN_SINGLE   = 8'h00;
    localparam logic [2:0]  AXI_SIZE_4B      = 3'b010;
    localparam logic [1:0]  AXI_BURST_INCR   = 2'b01;
    localparam logic [1:0]  AXI_RESP_DECERR  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_HOLD = 3'd3,
        ST_WAIT = 3'd4
    } ifu_state_e;

    // Redirect bus is {taken, target}; a not-taken retirement falls through (wraps mod 2^32).
    function automatic logic [31:0] next_pc(input logic [32:0] redir, input logic [31:0] pc);
        return redir[32] ? redir[31:0] : pc + 32'd4;
    endfunction

endpackage

// File: rtl/ysyx_23060208_ifu_fetch.sv
// rtl/ysyx_23060208_ifu_fetch.sv - single-issue instruction fetch stage with AXI4 read master
module ysyx_23060208_ifu_fetch
    import ysyx_23060208_ifu_fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [3:0]            AXI_ID     = 4'h1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [DATA_WIDTH:0]       exu_to_ifu_bus,
    input  logic                      exu_to_ifu_valid,
    output logic                      isram_arvalid,
    input  logic                      isram_arready,
    output logic [DATA_WIDTH-1:0]     isram_araddr,
    output logic [3:0]                isram_arid,
    output logic [7:0]                isram_arlen,
    output logic [2:0]                isram_arsize,
    output logic [1:0]                isram_arburst,
    input  logic                      isram_rvalid,
    output logic                      isram_rready,
    input  logic [2*DATA_WIDTH-1:0]   isram_rdata,
    input  logic [1:0]                isram_rresp,
    input  logic                      isram_rlast,
    input  logic [3:0]                isram_rid,
    output logic [2*DATA_WIDTH-1:0]   ifu_to_idu_bus,
    output logic                      ifu_to_idu_valid,
    input  logic                      idu_allowin,
    output logic                      ifu_done,
    output logic                      ifu_access_fault
);

    ifu_state_e state_q, state_d;

    logic [DATA_WIDTH-1:0] pc_q,    pc_d;
    logic [DATA_WIDTH-1:0] inst_q,  inst_d;
    logic                  pend_q,  pend_d;
    logic [DATA_WIDTH:0]   redir_q, redir_d;
    logic                  done_q,  done_d;
    logic                  fault_q, fault_d;

    logic misaligned;
    logic ar_fire;
    logic r_fire;
    logic exu_in_flight;
    logic wait_go;

    // The slave is trusted to send single-beat bursts, so rlast carries no information here.
    logic unused_rlast;
    assign unused_rlast = isram_rlast;

    assign misaligned    = (pc_q[1:0] != 2'b00);
    assign ar_fire       = (state_q == ST_AR) && !misaligned && isram_arready;
    assign r_fire        = (state_q == ST_R) && isram_rvalid && (isram_rid == AXI_ID);
    assign exu_in_flight = exu_to_ifu_valid &&
                           ((state_q == ST_AR) || (state_q == ST_R) || (state_q == ST_HOLD));
    assign wait_go       = (state_q == ST_WAIT) && (pend_q || exu_to_ifu_valid);

    // State register; reset abandons any outstanding transaction.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode for the fetch loop IDLE/AR -> R -> HOLD -> WAIT -> AR.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: state_d = ST_AR;
            ST_AR: begin
                if (misaligned) begin
                    state_d = ST_HOLD;
                end else if (ar_fire) begin
                    state_d = ST_R;
                end
            end
            ST_R:    if (r_fire)      state_d = ST_HOLD;
            ST_HOLD: if (idu_allowin) state_d = ST_WAIT;
            ST_WAIT: if (wait_go)     state_d = ST_AR;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next-state: instruction latch, redirect buffer, PC update and event pulses.
    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        pend_d  = pend_q;
        redir_d = redir_q;
        done_d  = 1'b0;
        fault_d = 1'b0;
        if ((state_q == ST_AR) && misaligned) begin
            inst_d  = EBREAK_INST;
            fault_d = 1'b1;
        end
        if (r_fire) begin
            inst_d  = pc_q[2] ? isram_rdata[2*DATA_WIDTH-1:DATA_WIDTH] : isram_rdata[DATA_WIDTH-1:0];
            done_d  = 1'b1;
            fault_d = (isram_rresp == AXI_RESP_DECERR);
        end
        if (exu_in_flight) begin
            pend_d  = 1'b1;
            redir_d = exu_to_ifu_bus;
        end
        if (wait_go) begin
            pc_d   = next_pc(pend_q ? redir_q : exu_to_ifu_bus, pc_q);
            pend_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            pend_q  <= 1'b0;
            redir_q <= '0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            pend_q  <= pend_d;
            redir_q <= redir_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

    // Handshake outputs decoded from the state register only, so reset clears them at once.
    always_comb begin
        isram_arvalid    = (state_q == ST_AR) && !misaligned;
        isram_araddr     = (state_q == ST_AR) ? pc_q : '0;
        isram_rready     = (state_q == ST_R);
        ifu_to_idu_valid = (state_q == ST_HOLD);
        ifu_to_idu_bus   = (state_q == ST_HOLD) ? {pc_q, inst_q} : '0;
        ifu_done         = done_q;
        ifu_access_fault = fault_q;
    end

    assign isram_arid    = AXI_ID;
    assign isram_arlen   = AXI_LEN_SINGLE;
    assign isram_arsize  = AXI_SIZE_4B;
    assign isram_arburst = AXI_BURST_INCR;

    // A second retirement before the buffered one is consumed would be lost.
    property p_single_redirect;
        @(posedge clock) disable iff (!reset) !(pend_q && exu_to_ifu_valid);
    endproperty
    assert property (p_single_redirect);

endmodule

// File: tb/tb_ysyx_23060208_ifu_fetch.sv
// tb/tb_ysyx_23060208_ifu_fetch.sv - self-checking bench for ysyx_23060208_ifu_fetch
module tb_ysyx_23060208_ifu_fetch;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clock;
    logic        reset;
    logic [32:0] exu_to_ifu_bus;
    logic        exu_to_ifu_valid;
    logic        isram_arvalid;
    logic        isram_arready;
    logic [31:0] isram_araddr;
    logic [3:0]  isram_arid;
    logic [7:0]  isram_arlen;
    logic [2:0]  isram_arsize;
    logic [1:0]  isram_arburst;
    logic        isram_rvalid;
    logic        isram_rready;
    logic [63:0] isram_rdata;
    logic [1:0]  isram_rresp;
    logic        isram_rlast;
    logic [3:0]  isram_rid;
    logic [63:0] ifu_to_idu_bus;
    logic        ifu_to_idu_valid;
    logic        idu_allowin;
    logic        ifu_done;
    logic        ifu_access_fault;

    int n_checks;
    int n_fail;

    ysyx_23060208_ifu_fetch dut (
        .clock            (clock),
        .reset            (reset),
        .exu_to_ifu_bus   (exu_to_ifu_bus),
        .exu_to_ifu_valid (exu_to_ifu_valid),
        .isram_arvalid    (isram_arvalid),
        .isram_arready    (isram_arready),
        .isram_araddr     (isram_araddr),
        .isram_arid       (isram_arid),
        .isram_arlen      (isram_arlen),
        .isram_arsize     (isram_arsize),
        .isram_arburst    (isram_arburst),
        .isram_rvalid     (isram_rvalid),
        .isram_rready     (isram_rready),
        .isram_rdata      (isram_rdata),
        .isram_rresp      (isram_rresp),
        .isram_rlast      (isram_rlast),
        .isram_rid        (isram_rid),
        .ifu_to_idu_bus   (ifu_to_idu_bus),
        .ifu_to_idu_valid (ifu_to_idu_valid),
        .idu_allowin      (idu_allowin),
        .ifu_done         (ifu_done),
        .ifu_access_fault (ifu_access_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int unsigned ar_delay;
        bit          bad_rid;
        bit          exu_early;
        logic [63:0] rdata;
        logic [1:0]  rresp;
        bit          taken;
        logic [31:0] target;
        logic [31:0] exp_addr;
        logic [31:0] exp_inst;
        bit          exp_fault;
    } vec_t;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int unsigned dly, input bit bad, input bit early,
                                input logic [63:0] rd, input logic [1:0] rr, input bit tk,
                                input logic [31:0] tgt, input logic [31:0] ea,
                                input logic [31:0] ei, input bit ef);
        vec_t v;
        v.ar_delay = dly; v.bad_rid = bad; v.exu_early = early; v.rdata = rd; v.rresp = rr;
        v.taken = tk; v.target = tgt; v.exp_addr = ea; v.exp_inst = ei; v.exp_fault = ef;
        return v;
    endfunction

    // Drives one full fetch from AR entry until the DUT is back in AR; entered just after a negedge.
    task automatic do_instr(input vec_t v);
        int n;
        bit mis;
        mis = (v.exp_addr[1:0] != 2'b00);
        n = 0;
        while (!isram_arvalid && !ifu_to_idu_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) begin
            chk("fetch_start_timeout", 96'(1), 96'(0));
            return;
        end
        if (mis) begin
            chk("misaligned_no_arvalid", 96'(isram_arvalid), 96'(0));
        end else begin
            chk("araddr", {63'(0), isram_arvalid, isram_araddr}, {63'(0), 1'b1, v.exp_addr});
            chk("ar_consts", 96'({isram_arid, isram_arlen, isram_arsize, isram_arburst}),
                96'({4'h1, 8'h00, 3'b010, 2'b01}));
            for (int i = 0; i < int'(v.ar_delay); i++) begin
                @(negedge clock);
                chk("araddr_stable", {63'(0), isram_arvalid, isram_araddr}, {63'(0), 1'b1, v.exp_addr});
            end
            isram_arready = 1'b1;
            @(negedge clock);
            isram_arready = 1'b0;
            chk("r_phase", 96'({isram_rready, isram_arvalid}), 96'(2'b10));
            if (v.bad_rid) begin
                isram_rvalid = 1'b1; isram_rid = 4'h3; isram_rdata = ~v.rdata; isram_rresp = 2'b00;
                @(negedge clock);
                chk("bad_rid_ignored", 96'({isram_rready, ifu_to_idu_valid, ifu_done}), 96'(3'b100));
            end
            isram_rvalid = 1'b1; isram_rid = 4'h1; isram_rdata = v.rdata; isram_rresp = v.rresp;
            @(negedge clock);
            isram_rvalid = 1'b0; isram_rid = 4'h0; isram_rdata = '0; isram_rresp = 2'b00;
        end
        chk("idu_valid", 96'(ifu_to_idu_valid), 96'(1));
        chk("idu_bus", 96'(ifu_to_idu_bus), 96'({v.exp_addr, v.exp_inst}));
        chk("done_pulse", 96'(ifu_done), 96'(!mis));
        chk("fault_pulse", 96'(ifu_access_fault), 96'(v.exp_fault));
        if (v.exu_early) begin
            exu_to_ifu_valid = 1'b1;
            exu_to_ifu_bus   = {v.taken, v.target};
        end
        @(negedge clock);
        exu_to_ifu_valid = 1'b0;
        exu_to_ifu_bus   = 33'h1_DEAD_0000;
        chk("hold_stable", {31'(0), ifu_to_idu_valid, ifu_to_idu_bus}, {31'(0), 1'b1, v.exp_addr, v.exp_inst});
        chk("pulses_single", 96'({ifu_done, ifu_access_fault}), 96'(0));
        idu_allowin = 1'b1;
        @(negedge clock);
        idu_allowin = 1'b0;
        chk("wait_idle", 96'({ifu_to_idu_valid, isram_arvalid, isram_rready}), 96'(0));
        if (!v.exu_early) begin
            exu_to_ifu_valid = 1'b1;
            exu_to_ifu_bus   = {v.taken, v.target};
        end
        @(negedge clock);
        exu_to_ifu_valid = 1'b0;
        exu_to_ifu_bus   = '0;
    endtask

    vec_t        tbl[7];
    vec_t        v;
    logic [31:0] model_pc;
    localparam int N_RAND = 40;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        tbl[0] = mk(0, 0, 0, 64'h0000_0000_0041_0113, 2'b00, 0, 32'h1234_5678, 32'h8000_0000, 32'h0041_0113, 0);
        tbl[1] = mk(0, 0, 0, 64'hDEAD_BEEF_0000_0013, 2'b00, 1, 32'h8000_0100, 32'h8000_0004, 32'hDEAD_BEEF, 0);
        tbl[2] = mk(5, 1, 1, 64'h1111_2222_3333_4444, 2'b00, 0, 32'h0000_0000, 32'h8000_0100, 32'h3333_4444, 0);
        tbl[3] = mk(1, 0, 1, 64'h5555_6666_7777_8888, 2'b11, 1, 32'h8000_0102, 32'h8000_0104, 32'h5555_6666, 1);
        tbl[4] = mk(0, 0, 0, 64'h0,                   2'b00, 1, 32'hFFFF_FFFC, 32'h8000_0102, EBREAK,        1);
        tbl[5] = mk(0, 0, 1, 64'hAAAA_BBBB_CCCC_DDDD, 2'b00, 0, 32'h8000_0000, 32'hFFFF_FFFC, 32'hAAAA_BBBB, 0);
        tbl[6] = mk(2, 0, 0, 64'h0123_4567_89AB_CDEF, 2'b00, 1, 32'h8000_0000, 32'h0000_0000, 32'h89AB_CDEF, 0);

        reset = 1'b1;
        exu_to_ifu_bus = '0; exu_to_ifu_valid = 1'b0;
        isram_arready = 1'b0; isram_rvalid = 1'b0; isram_rdata = '0; isram_rresp = 2'b00;
        isram_rlast = 1'b1; isram_rid = 4'h0; idu_allowin = 1'b0;
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_outputs", {30'(0), isram_arvalid, isram_rready, isram_araddr, ifu_to_idu_bus[31:0]},
            96'(0));
        chk("reset_bus_flags", {ifu_to_idu_bus[63:32], 61'(0), ifu_to_idu_valid, ifu_done, ifu_access_fault},
            96'(0));
        chk("reset_ar_consts", 96'({isram_arid, isram_arlen, isram_arsize, isram_arburst}),
            96'({4'h1, 8'h00, 3'b010, 2'b01}));
        reset = 1'b1;
        #1;
        chk("idle_after_release", 96'(isram_arvalid), 96'(0));
        @(negedge clock);
        chk("arvalid_cycle2", 96'(isram_arvalid), 96'(1));

        for (int i = 0; i < 7; i++) begin
            do_instr(tbl[i]);
        end

        model_pc = 32'h8000_0000;
        for (int i = 0; i < N_RAND; i++) begin
            v.ar_delay  = $urandom_range(0, 3);
            v.bad_rid   = 1'($urandom_range(0, 1));
            v.exu_early = 1'($urandom_range(0, 1));
            v.rdata     = {$urandom, $urandom};
            v.rresp     = 2'($urandom_range(0, 3));
            v.taken     = 1'($urandom_range(0, 1));
            v.target    = 32'h8000_0000 + 32'($urandom_range(0, 255)) * 32'd4;
            if (i != N_RAND - 1 && $urandom_range(0, 7) == 0) v.target = v.target + 32'd2;
            if (i == N_RAND - 1) v.taken = 1'b1;
            v.exp_addr = model_pc;
            if (model_pc % 4 != 0) begin
                v.exp_inst  = EBREAK;
                v.exp_fault = 1'b1;
            end else begin
                v.exp_inst  = ((model_pc / 4) % 2 == 1) ? v.rdata[63:32] : v.rdata[31:0];
                v.exp_fault = (v.rresp == 2'b11);
            end
            do_instr(v);
            model_pc = v.taken ? v.target : model_pc + 32'd4;
        end

        chk("rand_end_arvalid", 96'(isram_arvalid), 96'(1));
        isram_arready = 1'b1;
        @(negedge clock);
        isram_arready = 1'b0;
        chk("pre_reset_in_r", 96'(isram_rready), 96'(1));
        reset = 1'b0;
        #1;
        chk("reset_mid_r", 96'({isram_arvalid, isram_rready, ifu_to_idu_valid}), 96'(0));
        @(negedge clock);
        @(negedge clock);
        chk("reset_held_quiet", 96'({isram_arvalid, isram_rready, ifu_to_idu_valid}), 96'(0));
        reset = 1'b1;
        @(negedge clock);
        do_instr(mk(0, 0, 0, 64'h0000_0000_0000_0513, 2'b00, 0, 32'h0, 32'h8000_0000, 32'h0000_0513, 0));
        chk("refetch_next", {63'(0), isram_arvalid, isram_araddr}, {63'(0), 1'b1, 32'h8000_0004});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
